// File: rtl/rom_copy_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rom_copy_sequencer_pkg
//   Shared definitions for the ROM copy sequencer: copier state encoding and
//   the address/data widths of the ROM and destination ports.
// ---------------------------------------------------------------------------
package rom_copy_sequencer_pkg;

   localparam int ROM_AW = 14;   // ROM address width
   localparam int DATA_W = 8;    // ROM / destination data width
   localparam int DST_AW = 24;   // destination byte address width

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CAPT,
      ST_PUSH,
      ST_DONE
   } state_t;

endpackage

// File: rtl/rom_copy_sequencer.sv
// ---------------------------------------------------------------------------
// rom_copy_sequencer
//   Copies COPY_LEN bytes from an external synchronous ROM (1-cycle read
//   latency) to a destination write port at DST_BASE + index. The ROM port is
//   shared with a CPU read channel that always has priority.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle copy request (accepted in IDLE / DONE)
//   busy, done           copy in progress / last copy complete
//   rom_a, rom_dout      ROM address out, ROM data in (valid next cycle)
//   cpu_req, cpu_a       CPU read request (level) and address
//   cpu_ack, cpu_dout    one-cycle acknowledge with read data
//   wr_valid, wr_addr,   destination write request, address, data
//   wr_data, wr_ready    destination accept
// ---------------------------------------------------------------------------
module rom_copy_sequencer
   import rom_copy_sequencer_pkg::*;
#(
   parameter int          COPY_LEN = 9216,
   parameter logic [23:0] DST_BASE = 24'h000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ROM_AW-1:0] rom_a,
   input  logic [DATA_W-1:0] rom_dout,
   input  logic              cpu_req,
   input  logic [ROM_AW-1:0] cpu_a,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_dout,
   output logic              wr_valid,
   output logic [DST_AW-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ready
);

   localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(COPY_LEN - 1);

   state_t              state, state_nxt;
   logic [ROM_AW-1:0]   ptr, ptr_nxt;
   logic [DATA_W-1:0]   data_q, data_nxt;
   logic                ack_q;
   logic                cpu_grant;

   // The cycle after a grant is the ack cycle: the ROM is returning CPU data
   // then, so the CPU is not granted again and the copier may use the port.
   assign cpu_grant = cpu_req & ~ack_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         ptr    <= '0;
         data_q <= '0;
         ack_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         ptr    <= ptr_nxt;
         data_q <= data_nxt;
         ack_q  <= cpu_grant;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      data_nxt  = data_q;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               ptr_nxt   = '0;
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // A CPU grant owns rom_a this cycle; retry next cycle.
            if (!cpu_grant) state_nxt = ST_CAPT;
         end
         ST_CAPT: begin
            // rom_dout answers the FETCH address; a grant now only affects
            // next cycle's rom_dout, so the capture is safe.
            data_nxt  = rom_dout;
            state_nxt = ST_PUSH;
         end
         ST_PUSH: begin
            if (wr_ready) begin
               if (ptr == LAST_IDX) begin
                  state_nxt = ST_DONE;
               end else begin
                  ptr_nxt   = ptr + ROM_AW'(1);
                  state_nxt = ST_FETCH;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign rom_a    = cpu_grant ? cpu_a : ptr;
   assign cpu_ack  = ack_q;
   assign cpu_dout = ack_q ? rom_dout : '0;

   assign wr_valid = (state == ST_PUSH);
   assign wr_addr  = DST_BASE + DST_AW'(ptr);
   assign wr_data  = data_q;

   assign busy = (state == ST_FETCH) || (state == ST_CAPT) || (state == ST_PUSH);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_rom_copy_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rom_copy_sequencer
//   Self-checking bench: table-driven copy scenarios, a constrained random
//   phase and a mid-copy reset, all scored against a behavioural model of the
//   copy (byte order, handshakes, busy/done) and of the CPU read channel.
// ---------------------------------------------------------------------------
module tb_rom_copy_sequencer;

   localparam int          LEN = 4;
   localparam logic [23:0] DST = 24'h000100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        busy, done;
   logic [13:0] rom_a;
   logic [7:0]  rom_dout = 8'h00;
   logic        cpu_req;
   logic [13:0] cpu_a;
   logic        cpu_ack;
   logic [7:0]  cpu_dout;
   logic        wr_valid;
   logic [23:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ready;

   logic [7:0]  mem [0:16383];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rom_copy_sequencer #(.COPY_LEN(LEN), .DST_BASE(DST)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rom_a    (rom_a),
      .rom_dout (rom_dout),
      .cpu_req  (cpu_req),
      .cpu_a    (cpu_a),
      .cpu_ack  (cpu_ack),
      .cpu_dout (cpu_dout),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready)
   );

   // External synchronous ROM, 1-cycle read latency.
   always @(posedge clk) rom_dout <= mem[rom_a];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model / scoreboard ----------------
   bit          m_busy, m_done, m_ack_pend, prev_stall;
   int          m_idx, since_start, first_lat, hs_count, acks, cyc;
   logic [13:0] m_ack_a;
   logic [23:0] prev_addr;
   logic [7:0]  prev_data;
   int          hs_cyc[$];

   always @(negedge clk) begin
      bit grant;
      cyc++;
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_idx = 0; m_ack_pend = 0;
         prev_stall = 0; since_start = 0; first_lat = -1;
      end else begin
         check("busy", busy, m_busy);
         check("done", done, m_done);
         // CPU channel: ack one cycle after each grant, with that address's byte.
         if (m_ack_pend) begin
            check("cpu_ack", cpu_ack, 1);
            check("cpu_dout", cpu_dout, mem[m_ack_a]);
            acks++;
         end else begin
            check("cpu_ack_idle", cpu_ack, 0);
         end
         grant = cpu_req && !m_ack_pend;
         if (grant) check("rom_a_cpu", rom_a, cpu_a);
         m_ack_pend = grant;
         m_ack_a    = cpu_a;
         // Stalled write must hold its request and payload.
         if (prev_stall) begin
            check("stall_valid", wr_valid, 1);
            check("stall_addr", wr_addr, prev_addr);
            check("stall_data", wr_data, prev_data);
         end
         prev_stall = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
         if (!m_busy) check("wr_valid_idle", wr_valid, 0);
         if (m_busy) begin
            since_start++;
            if (wr_valid && first_lat < 0) first_lat = since_start;
         end
         // Copy progress: bytes leave strictly in order 0..LEN-1.
         if (wr_valid && wr_ready) begin
            check("wr_addr", wr_addr, DST + 24'(m_idx));
            check("wr_data", wr_data, mem[m_idx]);
            hs_count++;
            hs_cyc.push_back(cyc);
            if (m_idx == LEN - 1) begin
               m_busy = 0; m_done = 1;
            end else begin
               m_idx++;
            end
         end else if (start && !m_busy) begin
            m_busy = 1; m_done = 0; m_idx = 0; since_start = 0; first_lat = -1;
         end
      end
   end

   // ---------------- scenario table ----------------
   typedef struct {
      string name;
      int    stall_len;    // wr_ready low for this many cycles from first PUSH
      int    cpu_mode;     // 0 none, 1 held 20 cycles, 2 one request in CAPT
      bit    extra_start;  // pulse start while busy
      int    exp_writes;
      int    exp_acks;
      bit    exp_done;
      bit    exp_busy;
   } vec_t;

   vec_t vecs [5];

   task automatic run_copy(input vec_t v, output int writes, output int nacks);
      int hs0 = hs_count;
      int ack0 = acks;
      bit fin = 0;
      @(posedge clk); #1;
      start = 1;
      for (int k = 1; k <= 300 && !fin; k++) begin
         @(posedge clk); #1;
         start    = v.extra_start && (k == 2 || k == 5);
         wr_ready = !(k >= 3 && k < 3 + v.stall_len);
         case (v.cpu_mode)
            1: begin
               cpu_req = (k <= 20);
               if (k % 2 == 1) cpu_a = 14'($urandom);
            end
            2: begin
               cpu_req = (k == 2);
               if (k == 2) cpu_a = 14'($urandom);
            end
            default: cpu_req = 0;
         endcase
         if (done && k > 22) fin = 1;
      end
      start = 0; cpu_req = 0; wr_ready = 1;
      if (!fin) check("copy_timeout", 0, 1);
      writes = hs_count - hs0;
      nacks  = acks - ack0;
   endtask

   task automatic check_reset_outputs();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_cpu_dout", cpu_dout, 0);
      check("rst_rom_a", rom_a, 0);
   endtask

   initial begin
      int  w, a;
      bit  found;
      vecs[0] = '{"plain",       0, 0, 0, LEN, 0,  1, 0};
      vecs[1] = '{"ready_stall", 5, 0, 0, LEN, 0,  1, 0};
      vecs[2] = '{"cpu_hold",    0, 1, 0, LEN, 10, 1, 0};
      vecs[3] = '{"start_busy",  0, 0, 1, LEN, 0,  1, 0};
      vecs[4] = '{"cpu_in_capt", 0, 2, 0, LEN, 1,  1, 0};

      for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
      start = 0; cpu_req = 0; cpu_a = 0; wr_ready = 1; rst_n = 0;
      #12;
      check_reset_outputs();
      @(posedge clk); #1;
      rst_n = 1;

      for (int i = 0; i < 5; i++) begin
         run_copy(vecs[i], w, a);
         check({vecs[i].name, "_writes"}, w, vecs[i].exp_writes);
         check({vecs[i].name, "_acks"}, a, vecs[i].exp_acks);
         check({vecs[i].name, "_done"}, done, vecs[i].exp_done);
         check({vecs[i].name, "_busy"}, busy, vecs[i].exp_busy);
         if (i == 0) begin
            check("first_wr_latency", first_lat, 3);
            for (int j = hs_cyc.size() - LEN + 1; j < hs_cyc.size(); j++)
               check("byte_interval", hs_cyc[j] - hs_cyc[j-1], 3);
         end
      end

      // Random phase: CPU follows its level/ack protocol, ready and start random.
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk); #1;
         start    = ($urandom_range(0, 24) == 0);
         wr_ready = ($urandom_range(0, 3) != 0);
         if (!cpu_req || cpu_ack) begin
            cpu_req = ($urandom_range(0, 3) == 0);
            cpu_a   = 14'($urandom);
         end
      end
      start = 0; cpu_req = 0; wr_ready = 1;
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(posedge clk); #1;
         if (!busy) found = 1;
      end
      check("random_drain", found, 1);

      // Reset while byte 2 is being offered; the copy must not resume.
      @(posedge clk); #1;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(posedge clk); #1;
         if (wr_valid && wr_addr == DST + 24'd2) found = 1;
      end
      check("reach_byte2", found, 1);
      #2 rst_n = 0;
      #1 check_reset_outputs();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      repeat (4) @(posedge clk);
      #1 check("no_resume_busy", busy, 0);
      run_copy(vecs[0], w, a);
      check("restart_writes", w, LEN);
      check("restart_done", done, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
